// File: rtl/ahb_pkg.sv
// Shared AHB encodings, widths and the burst-length helper used by the arbiter.
package ahb_pkg;

    localparam int HMASTER_W = 4;
    localparam int BEAT_W    = 5;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    // Beats still to come after the first one of a fixed-length burst.
    // Undefined-length (INCR) and SINGLE transfers never block arbitration.
    function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] hburst);
        logic [BEAT_W-1:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd15;
            default:                      beats = 5'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration signals shared between the bus masters and the arbiter.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 3
);
    import ahb_pkg::*;

    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic [2:0]             HBURST;
    logic                   HREADY;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [HMASTER_W-1:0]   HMASTER;
    logic                   HMASTLOCK;

    // Master side: drives requests and the current transfer, sees grants.
    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    // Slave side: the arbiter itself.
    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        output HGRANT, HMASTER, HMASTLOCK
    );

endinterface

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last`,
// wrapping around; `last` itself is only chosen if nobody else asks.
module ahb_rr_pick
    import ahb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [HMASTER_W-1:0] last,
    output logic [N-1:0]         gnt,
    output logic                 valid
);

    logic [N-1:0] above;
    logic [N-1:0] req_hi;

    // Mask of indices with higher number than the last winner.
    for (genvar gi = 0; gi < N; gi++) begin : g_above
        assign above[gi] = (HMASTER_W'(gi) > last);
    end

    assign req_hi = req & above;

    // Lowest set bit above the last winner, otherwise wrap to the lowest overall.
    always_comb begin
        gnt   = '0;
        valid = |req;
        if (|req_hi) begin
            gnt = req_hi & (-req_hi);
        end else begin
            gnt = req & (-req);
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with burst and lock protection, default-master
// parking, and registered HGRANT/HMASTER/HMASTLOCK.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_bus_arbiter_if.slave   bus
);

    localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [HMASTER_W-1:0]   DEF_IDX = HMASTER_W'(DEFAULT_MASTER);

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [HMASTER_W-1:0]   hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [BEAT_W-1:0]      cnt_q, cnt_d;

    logic [HMASTER_W-1:0]   owner_idx;
    logic                   owner_lock;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_valid;

    // Index and lock request of the currently granted master.
    always_comb begin
        owner_idx  = '0;
        owner_lock = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                owner_idx  = HMASTER_W'(i);
                owner_lock = bus.HLOCK[i];
            end
        end
    end

    // Rotation starts after the granted master so full contention cycles 0,1,2,0.
    ahb_rr_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .req   (bus.HBUSREQ),
        .last  (owner_idx),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // Beat tracking, handover and re-arbitration, all gated by HREADY.
    always_comb begin
        grant_d     = grant_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        cnt_d       = cnt_q;
        if (bus.HREADY) begin
            case (bus.HTRANS)
                HTRANS_NONSEQ: cnt_d = burst_beats(bus.HBURST);
                HTRANS_SEQ:    cnt_d = (cnt_q != '0) ? cnt_q - 5'd1 : cnt_q;
                HTRANS_BUSY:   cnt_d = cnt_q;
                default:       cnt_d = '0;
            endcase
            // Address phase moves to whoever held the grant before this edge.
            hmaster_d   = owner_idx;
            hmastlock_d = owner_lock;
            // Only re-arbitrate once the burst is done and no lock is held.
            if ((cnt_d == '0) && !owner_lock) begin
                grant_d = pick_valid ? pick_gnt : DEF_GNT;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            grant_q     <= DEF_GNT;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            grant_q     <= grant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = hmaster_q;
    assign bus.HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (3 masters, default master 0) with a
// transfer-level reference model and per-cycle comparison.
module tb_ahb_bus_arbiter;

    localparam int N = 3;

    logic clk;
    logic rstn;
    int   total;
    int   bad;
    bit   chk_en;

    // Reference model state: granted master, address-phase owner, lock, beats left.
    int   m_g;
    int   m_own;
    int   m_lk;
    int   m_left;

    ahb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

    ahb_bus_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (0)
    ) dut (
        .HCLK    (clk),
        .HRESETn (rstn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of beats in a burst as defined by the AHB burst type.
    function automatic int burst_len(input logic [2:0] b);
        if (b < 3'd2) return 1;
        if (b < 3'd4) return 4;
        if (b < 3'd6) return 8;
        return 16;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        int nl;
        int win;
        bit owner_locked;
        if (!rstn) begin
            m_g = 0; m_own = 0; m_lk = 0; m_left = 0;
        end else if (bus.HREADY) begin
            case (bus.HTRANS)
                2'd2:    nl = burst_len(bus.HBURST) - 1;
                2'd3:    nl = (m_left > 0) ? m_left - 1 : 0;
                2'd1:    nl = m_left;
                default: nl = 0;
            endcase
            owner_locked = bus.HLOCK[m_g];
            m_own = m_g;
            m_lk  = owner_locked ? 1 : 0;
            if (nl == 0 && !owner_locked) begin
                win = 0;
                for (int k = N; k >= 1; k--) begin
                    if (bus.HBUSREQ[(m_g + k) % N]) win = (m_g + k) % N;
                end
                m_g = win;
            end
            m_left = nl;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (bus.HGRANT !== 3'(1 << m_g)) begin
                bad++;
                $display("FAIL model_grant got=%b want=%b t=%0t", bus.HGRANT, 3'(1 << m_g), $time);
            end
            total++;
            if (bus.HMASTER !== 4'(m_own)) begin
                bad++;
                $display("FAIL model_hmaster got=%0d want=%0d t=%0t", bus.HMASTER, m_own, $time);
            end
            total++;
            if (bus.HMASTLOCK !== 1'(m_lk)) begin
                bad++;
                $display("FAIL model_hmastlock got=%b want=%0d t=%0t", bus.HMASTLOCK, m_lk, $time);
            end
            total++;
            if (!$onehot(bus.HGRANT)) begin
                bad++;
                $display("FAIL grant_onehot got=%b want=one-hot t=%0t", bus.HGRANT, $time);
            end
        end
    end

    // One transaction: drive inputs, take an edge, check hand-computed values.
    task automatic cyc(input logic r, input logic [2:0] req, input logic [2:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                       input int eg, input int em, input string tag);
        rstn        = r;
        bus.HBUSREQ = req;
        bus.HLOCK   = lk;
        bus.HTRANS  = tr;
        bus.HBURST  = bu;
        bus.HREADY  = rdy;
        @(posedge clk);
        model_edge();
        #1;
        if (eg >= 0) begin
            total++;
            if (bus.HGRANT !== 3'(eg)) begin
                bad++;
                $display("FAIL %s grant got=%b want=%b", tag, bus.HGRANT, 3'(eg));
            end
        end
        if (em >= 0) begin
            total++;
            if (bus.HMASTER !== 4'(em)) begin
                bad++;
                $display("FAIL %s hmaster got=%0d want=%0d", tag, bus.HMASTER, em);
            end
        end
        chk_en = 1'b1;
        $display("txn %-8s rstn=%b req=%b lock=%b trans=%0d burst=%0d ready=%b -> grant=%b hmaster=%0d lock=%b",
                 tag, r, req, lk, tr, bu, rdy, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK);
    endtask

    initial begin
        total = 0; bad = 0; chk_en = 1'b0;
        m_g = 0; m_own = 0; m_lk = 0; m_left = 0;

        // Reset and park on the default master.
        cyc(0, 3'b000, 3'b000, 2'd0, 3'd0, 1, 1, 0, "reset");
        cyc(0, 3'b000, 3'b000, 2'd0, 3'd0, 1, 1, 0, "reset");
        for (int i = 0; i < 3; i++) cyc(1, 3'b000, 3'b000, 2'd0, 3'd0, 1, 1, 0, "park");

        // Round-robin of single transfers under full contention.
        cyc(1, 3'b111, 3'b000, 2'd2, 3'd0, 1, 3'b010, 0, "rr");
        cyc(1, 3'b111, 3'b000, 2'd2, 3'd0, 1, 3'b100, 1, "rr");
        cyc(1, 3'b111, 3'b000, 2'd2, 3'd0, 1, 3'b001, 2, "rr");
        cyc(1, 3'b111, 3'b000, 2'd2, 3'd0, 1, 3'b010, 0, "rr");

        // INCR4 by master 1 with master 2 waiting: handover on the 4th beat.
        cyc(1, 3'b110, 3'b000, 2'd2, 3'd3, 1, 3'b010, 1, "incr4");
        cyc(1, 3'b110, 3'b000, 2'd3, 3'd3, 1, 3'b010, 1, "incr4");
        cyc(1, 3'b110, 3'b000, 2'd3, 3'd3, 1, 3'b010, 1, "incr4");
        cyc(1, 3'b110, 3'b000, 2'd3, 3'd3, 1, 3'b100, 1, "incr4");
        cyc(1, 3'b010, 3'b000, 2'd2, 3'd0, 1, 3'b010, 2, "regrant");

        // Same INCR4 with three wait states on beat 2.
        cyc(1, 3'b110, 3'b000, 2'd2, 3'd3, 1, 3'b010, 1, "wait");
        for (int i = 0; i < 3; i++) cyc(1, 3'b110, 3'b000, 2'd3, 3'd3, 0, 3'b010, 1, "wait");
        cyc(1, 3'b110, 3'b000, 2'd3, 3'd3, 1, 3'b010, 1, "wait");
        cyc(1, 3'b110, 3'b000, 2'd3, 3'd3, 1, 3'b010, 1, "wait");
        cyc(1, 3'b110, 3'b000, 2'd3, 3'd3, 1, 3'b100, 1, "wait");

        // Locked sequence by master 0, then release.
        cyc(1, 3'b111, 3'b001, 2'd2, 3'd0, 1, 3'b001, 2, "lock");
        for (int i = 0; i < 3; i++) cyc(1, 3'b111, 3'b001, 2'd2, 3'd0, 1, 3'b001, 0, "lock");
        cyc(1, 3'b111, 3'b000, 2'd2, 3'd0, 1, 3'b010, 0, "unlock");

        // INCR8 terminated early with IDLE.
        cyc(1, 3'b101, 3'b000, 2'd2, 3'd5, 1, 3'b010, 1, "idle");
        cyc(1, 3'b101, 3'b000, 2'd3, 3'd5, 1, 3'b010, 1, "idle");
        cyc(1, 3'b101, 3'b000, 2'd0, 3'd5, 1, 3'b100, 1, "idle");

        // INCR8 aborted by reset, then SEQ with a cleared counter re-arbitrates.
        cyc(1, 3'b011, 3'b000, 2'd2, 3'd5, 1, 3'b100, 2, "rstmid");
        cyc(1, 3'b011, 3'b000, 2'd3, 3'd5, 1, 3'b100, 2, "rstmid");
        cyc(0, 3'b011, 3'b000, 2'd3, 3'd5, 1, 3'b001, 0, "rstmid");
        cyc(1, 3'b010, 3'b000, 2'd3, 3'd5, 1, 3'b010, 0, "rstmid");
        cyc(1, 3'b000, 3'b000, 2'd0, 3'd0, 1, 3'b001, 1, "park");

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
